// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller: FSM states,
// register index width and the packed pipeline-control word.
package hazard_pkg;

    localparam int REG_IDX_W        = 3;
    localparam int DEF_TIMEOUT      = 255;
    localparam int DEF_DRAIN_CYCLES = 3;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_HALTED  = 2'd3
    } state_e;

    // Bit order matches the way the pipeline registers are listed front to back.
    typedef struct packed {
        logic pc_write;
        logic pc_redirect;
        logic ifid_write;
        logic ifid_flush;
        logic idex_write;
        logic idex_bubble;
        logic exmem_write;
        logic memwb_write;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE     = 8'b0000_0000;
    localparam ctrl_t CTRL_NORMAL   = 8'b1010_1011;
    localparam ctrl_t CTRL_REDIRECT = 8'b1111_1111;
    localparam ctrl_t CTRL_LOADUSE  = 8'b0000_1111;
    localparam ctrl_t CTRL_HALT     = 8'b0011_1011;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller
// (slave). No handshake: every signal is a per-cycle level, sampled on clk.
interface pipe_hazard_ctrl_if;
    import hazard_pkg::*;

    logic                 id_valid;
    logic [REG_IDX_W-1:0] id_rs;
    logic [REG_IDX_W-1:0] id_rt;
    logic                 id_rs_used;
    logic                 id_rt_used;
    logic                 id_halt;
    logic                 ex_mem_read;
    logic [REG_IDX_W-1:0] ex_rd;
    logic                 ex_redirect;
    logic                 mem_busy;

    logic                 pc_write;
    logic                 pc_redirect;
    logic                 ifid_write;
    logic                 ifid_flush;
    logic                 idex_write;
    logic                 idex_bubble;
    logic                 exmem_write;
    logic                 memwb_write;
    logic                 halted;
    logic                 mem_timeout;
    logic [15:0]          stall_cycles;
    state_e               fsm_state;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_halt,
               ex_mem_read, ex_rd, ex_redirect, mem_busy,
        input  pc_write, pc_redirect, ifid_write, ifid_flush, idex_write,
               idex_bubble, exmem_write, memwb_write, halted, mem_timeout,
               stall_cycles, fsm_state
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_halt,
               ex_mem_read, ex_rd, ex_redirect, mem_busy,
        output pc_write, pc_redirect, ifid_write, ifid_flush, idex_write,
               idex_bubble, exmem_write, memwb_write, halted, mem_timeout,
               stall_cycles, fsm_state
    );

endinterface

// File: rtl/pipe_hazard_ctrl_detect.sv
// Load-use detector: the instruction in ID reads a register that the load
// currently in EX has not yet produced.
module hazard_detect
    import hazard_pkg::*;
(
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic                 id_rs_used,
    input  logic                 id_rt_used,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rd,
    output logic                 load_use
);

    assign load_use = id_valid & ex_mem_read &
                      ((id_rs_used & (id_rs == ex_rd)) |
                       (id_rt_used & (id_rt == ex_rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/stall controller: memory-wait freeze with timeout, branch
// squash, load-use stall and halt drain, plus a saturating stall counter.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int TIMEOUT      = DEF_TIMEOUT,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input logic              clk,
    input logic              rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT);
    localparam logic [7:0]  DRAIN_INIT  = 8'(DRAIN_CYCLES);

    state_e      state;
    state_e      state_next;
    logic [15:0] busy_cnt;
    logic [15:0] busy_next;
    logic [15:0] busy_inc;
    logic [7:0]  drain_cnt;
    logic [7:0]  drain_next;
    logic        timeout_set;
    logic        stall_inc;
    logic        halted_c;
    logic        mem_timeout;
    logic [15:0] stall_cycles;
    logic        load_use;
    ctrl_t       ctrl;
    ctrl_t       ctrl_out;

    hazard_detect u_detect (
        .id_valid    (bus.id_valid),
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .id_rs_used  (bus.id_rs_used),
        .id_rt_used  (bus.id_rt_used),
        .ex_mem_read (bus.ex_mem_read),
        .ex_rd       (bus.ex_rd),
        .load_use    (load_use)
    );

    // The first busy cycle is seen in RUN, so it counts as 1.
    assign busy_inc = (state == ST_MEMWAIT && busy_cnt != 16'hFFFF) ?
                      busy_cnt + 16'd1 : 16'd1;

    always_comb begin
        ctrl        = CTRL_NONE;
        state_next  = state;
        busy_next   = busy_cnt;
        drain_next  = drain_cnt;
        timeout_set = 1'b0;
        halted_c    = 1'b0;
        case (state)
            ST_RUN, ST_MEMWAIT: begin
                if (bus.mem_busy) begin
                    busy_next = busy_inc;
                    if (busy_inc >= TIMEOUT_LIM) begin
                        timeout_set = 1'b1;
                        state_next  = ST_HALTED;
                    end else begin
                        state_next = ST_MEMWAIT;
                    end
                end else begin
                    // Leaving MEMWAIT evaluates the pipeline in the same cycle.
                    busy_next  = '0;
                    state_next = ST_RUN;
                    if (bus.ex_redirect) begin
                        ctrl = CTRL_REDIRECT;
                    end else if (load_use) begin
                        ctrl = CTRL_LOADUSE;
                    end else if (bus.id_halt && bus.id_valid) begin
                        ctrl       = CTRL_HALT;
                        state_next = ST_DRAIN;
                        drain_next = DRAIN_INIT;
                    end else begin
                        ctrl = CTRL_NORMAL;
                    end
                end
            end
            ST_DRAIN: begin
                ctrl.ifid_write  = 1'b1;
                ctrl.ifid_flush  = 1'b1;
                ctrl.idex_bubble = 1'b1;
                ctrl.idex_write  = !bus.mem_busy;
                ctrl.exmem_write = !bus.mem_busy;
                ctrl.memwb_write = !bus.mem_busy;
                if (!bus.mem_busy) begin
                    if (drain_cnt <= 8'd1) begin
                        drain_next = '0;
                        state_next = ST_HALTED;
                    end else begin
                        drain_next = drain_cnt - 8'd1;
                    end
                end
            end
            default: begin
                halted_c = 1'b1;
            end
        endcase
    end

    assign stall_inc = ((state == ST_RUN) || (state == ST_MEMWAIT)) && !ctrl.pc_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_RUN;
            busy_cnt     <= '0;
            drain_cnt    <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state     <= state_next;
            busy_cnt  <= busy_next;
            drain_cnt <= drain_next;
            if (timeout_set) begin
                mem_timeout <= 1'b1;
            end
            if (stall_inc && stall_cycles != 16'hFFFF) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end

    // Reset holds the whole pipeline frozen, not just the FSM.
    assign ctrl_out = rst ? CTRL_NONE : ctrl;

    assign bus.pc_write     = ctrl_out.pc_write;
    assign bus.pc_redirect  = ctrl_out.pc_redirect;
    assign bus.ifid_write   = ctrl_out.ifid_write;
    assign bus.ifid_flush   = ctrl_out.ifid_flush;
    assign bus.idex_write   = ctrl_out.idex_write;
    assign bus.idex_bubble  = ctrl_out.idex_bubble;
    assign bus.exmem_write  = ctrl_out.exmem_write;
    assign bus.memwb_write  = ctrl_out.memwb_write;
    assign bus.halted       = halted_c & ~rst;
    assign bus.mem_timeout  = mem_timeout;
    assign bus.stall_cycles = stall_cycles;
    assign bus.fsm_state    = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a RUN-state vector table followed by
// hand sequences for memory wait/timeout, halt drain and asynchronous reset.
module tb_pipe_hazard_ctrl;
    import hazard_pkg::*;

    // Control word order: pc_write pc_redirect ifid_write ifid_flush
    //                     idex_write idex_bubble exmem_write memwb_write
    localparam logic [7:0] C_NONE       = 8'b0000_0000;
    localparam logic [7:0] C_NORM       = 8'b1010_1011;
    localparam logic [7:0] C_REDIR      = 8'b1111_1111;
    localparam logic [7:0] C_LU         = 8'b0000_1111;
    localparam logic [7:0] C_HALT       = 8'b0011_1011;
    localparam logic [7:0] C_DRAIN      = 8'b0011_1111;
    localparam logic [7:0] C_DRAIN_BUSY = 8'b0011_0100;
    localparam int         NV           = 12;

    typedef struct {
        string      name;
        logic       id_valid;
        logic [2:0] id_rs;
        logic [2:0] id_rt;
        logic       rs_used;
        logic       rt_used;
        logic       id_halt;
        logic       ex_mem_read;
        logic [2:0] ex_rd;
        logic       ex_redirect;
        logic       mem_busy;
        logic [7:0] exp_ctrl;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   exp_stall;
    vec_t tbl[NV];
    vec_t v_idle, v_busy, v_halt, v_lu, v_redir;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(.TIMEOUT(255), .DRAIN_CYCLES(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic vec_t mk(input string n, input logic vld, input logic [2:0] rs,
                                input logic [2:0] rt, input logic ru, input logic tu,
                                input logic h, input logic lr, input logic [2:0] rd,
                                input logic rdr, input logic mb, input logic [7:0] e);
        vec_t v;
        v.name = n; v.id_valid = vld; v.id_rs = rs; v.id_rt = rt;
        v.rs_used = ru; v.rt_used = tu; v.id_halt = h; v.ex_mem_read = lr;
        v.ex_rd = rd; v.ex_redirect = rdr; v.mem_busy = mb; v.exp_ctrl = e;
        return v;
    endfunction

    function automatic logic [7:0] ctrl_now();
        return {bus.pc_write, bus.pc_redirect, bus.ifid_write, bus.ifid_flush,
                bus.idex_write, bus.idex_bubble, bus.exmem_write, bus.memwb_write};
    endfunction

    task automatic apply(input vec_t v);
        bus.id_valid    = v.id_valid;
        bus.id_rs       = v.id_rs;
        bus.id_rt       = v.id_rt;
        bus.id_rs_used  = v.rs_used;
        bus.id_rt_used  = v.rt_used;
        bus.id_halt     = v.id_halt;
        bus.ex_mem_read = v.ex_mem_read;
        bus.ex_rd       = v.ex_rd;
        bus.ex_redirect = v.ex_redirect;
        bus.mem_busy    = v.mem_busy;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Drive at posedge+1, compare at the falling edge, return at next posedge+1.
    task automatic step(input vec_t v, input logic [7:0] exp_ctrl, input logic exp_halted);
        apply(v);
        @(negedge clk);
        chk({v.name, " ctrl"}, 32'(ctrl_now()), 32'(exp_ctrl));
        chk({v.name, " halted"}, 32'(bus.halted), 32'(exp_halted));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply(v_idle);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        v_idle  = mk("idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM);
        v_busy  = mk("busy",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_NONE);
        v_halt  = mk("halt",  1, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_HALT);
        v_lu    = mk("lu",    1, 3, 0, 1, 0, 0, 1, 3, 0, 0, C_LU);
        v_redir = mk("redir", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_REDIR);

        tbl[0]  = mk("t_idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM);
        tbl[1]  = mk("t_lu_rs",       1, 3, 1, 1, 0, 0, 1, 3, 0, 0, C_LU);
        tbl[2]  = mk("t_lu_rt",       1, 2, 5, 0, 1, 0, 1, 5, 0, 0, C_LU);
        tbl[3]  = mk("t_rs_unused",   1, 3, 1, 0, 1, 0, 1, 3, 0, 0, C_NORM);
        tbl[4]  = mk("t_id_invalid",  0, 3, 3, 1, 1, 0, 1, 3, 0, 0, C_NORM);
        tbl[5]  = mk("t_no_load",     1, 3, 3, 1, 1, 0, 0, 3, 0, 0, C_NORM);
        tbl[6]  = mk("t_redirect",    1, 4, 2, 1, 1, 0, 0, 6, 1, 0, C_REDIR);
        tbl[7]  = mk("t_redir_lu_hlt",1, 3, 0, 1, 0, 1, 1, 3, 1, 0, C_REDIR);
        tbl[8]  = mk("t_lu_over_halt",1, 0, 6, 0, 1, 1, 1, 6, 0, 0, C_LU);
        tbl[9]  = mk("t_halt_invalid",0, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_NORM);
        tbl[10] = mk("t_lu_r0",       1, 0, 2, 1, 0, 0, 1, 0, 0, 0, C_LU);
        tbl[11] = mk("t_no_match",    1, 7, 7, 1, 1, 0, 1, 6, 0, 0, C_NORM);

        // Reset values while rst is held
        rst = 1'b1;
        apply(v_idle);
        #3;
        chk("rst ctrl", 32'(ctrl_now()), 32'(C_NONE));
        chk("rst halted", 32'(bus.halted), 32'd0);
        chk("rst mem_timeout", 32'(bus.mem_timeout), 32'd0);
        chk("rst stall_cycles", 32'(bus.stall_cycles), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // RUN-state table, every row leaves the FSM in RUN
        exp_stall = 0;
        for (int i = 0; i < NV; i++) begin
            step(tbl[i], tbl[i].exp_ctrl, 1'b0);
            if (tbl[i].exp_ctrl[7] == 1'b0) exp_stall++;
            chk({tbl[i].name, " stall_cycles"}, 32'(bus.stall_cycles), 32'(exp_stall));
        end

        // Single load-use stall, then normal flow
        do_reset();
        step(v_lu, C_LU, 1'b0);
        step(v_idle, C_NORM, 1'b0);
        chk("lu stall_cycles", 32'(bus.stall_cycles), 32'd1);

        // Redirect wins over a squashed halt: no drain follows
        do_reset();
        step(tbl[7], C_REDIR, 1'b0);
        repeat (4) step(v_idle, C_NORM, 1'b0);

        // Halt drain, no memory stalls; redirect in DRAIN is ignored
        do_reset();
        step(v_halt, C_HALT, 1'b0);
        step(v_idle, C_DRAIN, 1'b0);
        step(v_redir, C_DRAIN, 1'b0);
        step(v_idle, C_DRAIN, 1'b0);
        step(v_idle, C_NONE, 1'b1);
        chk("drain3 stall_cycles", 32'(bus.stall_cycles), 32'd1);

        // Halt drain stretched by two busy cycles
        do_reset();
        step(v_halt, C_HALT, 1'b0);
        step(v_idle, C_DRAIN, 1'b0);
        step(v_busy, C_DRAIN_BUSY, 1'b0);
        step(v_busy, C_DRAIN_BUSY, 1'b0);
        step(v_idle, C_DRAIN, 1'b0);
        step(v_idle, C_DRAIN, 1'b0);
        step(v_idle, C_NONE, 1'b1);
        chk("drain5 stall_cycles", 32'(bus.stall_cycles), 32'd1);

        // mem_busy for TIMEOUT cycles -> sticky timeout and HALTED
        do_reset();
        for (int i = 1; i <= 255; i++) begin
            if (i == 255) chk("timeout early", 32'(bus.mem_timeout), 32'd0);
            step(v_busy, C_NONE, 1'b0);
        end
        chk("timeout set", 32'(bus.mem_timeout), 32'd1);
        chk("timeout stall_cycles", 32'(bus.stall_cycles), 32'd255);
        repeat (3) step(v_idle, C_NONE, 1'b1);
        chk("halted stall_cycles", 32'(bus.stall_cycles), 32'd255);
        chk("halted mem_timeout", 32'(bus.mem_timeout), 32'd1);

        // mem_busy for TIMEOUT-1 cycles, exit straight into a load-use stall
        do_reset();
        repeat (254) step(v_busy, C_NONE, 1'b0);
        step(v_lu, C_LU, 1'b0);
        step(v_idle, C_NORM, 1'b0);
        chk("254 mem_timeout", 32'(bus.mem_timeout), 32'd0);
        chk("254 stall_cycles", 32'(bus.stall_cycles), 32'd255);

        // Asynchronous reset in the middle of DRAIN
        do_reset();
        step(v_halt, C_HALT, 1'b0);
        step(v_idle, C_DRAIN, 1'b0);
        apply(v_idle);
        #2;
        rst = 1'b1;
        #1;
        chk("midrain rst ctrl", 32'(ctrl_now()), 32'(C_NONE));
        chk("midrain rst halted", 32'(bus.halted), 32'd0);
        chk("midrain rst stall_cycles", 32'(bus.stall_cycles), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) step(v_idle, C_NORM, 1'b0);

        // Asynchronous reset in MEMWAIT discards the timeout progress
        do_reset();
        repeat (100) step(v_busy, C_NONE, 1'b0);
        apply(v_busy);
        #2;
        rst = 1'b1;
        #1;
        chk("midwait rst stall_cycles", 32'(bus.stall_cycles), 32'd0);
        chk("midwait rst ctrl", 32'(ctrl_now()), 32'(C_NONE));
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (200) step(v_busy, C_NONE, 1'b0);
        step(v_idle, C_NORM, 1'b0);
        chk("midwait mem_timeout", 32'(bus.mem_timeout), 32'd0);
        chk("midwait stall_cycles", 32'(bus.stall_cycles), 32'd200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
